alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU instance among NUM_REQ requesters, such as the execute stage, address generation and a debug port.
- Picks one request per cycle using round-robin arbitration, holds its operands in an issue register that drives the ALU, and captures the ALU result and flags into a response register.
- Uses valid/ready handshakes on both sides. Sustains one operation per cycle when unstalled.

Parameters:
- DATA_WIDTH, 64, width of operands and result.
- NUM_REQ, 2, number of requesters (2..8).
- ID_WIDTH, $clog2(NUM_REQ) (minimum 1), width of the requester index.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  request valid, one bit per requester.
- req_ready  output  NUM_REQ  request accepted this cycle, one-hot or zero.
- req_A  input  NUM_REQ*DATA_WIDTH  operand A per requester; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_B  input  NUM_REQ*DATA_WIDTH  operand B per requester, same packing as req_A.
- req_cntrl  input  NUM_REQ*3  ALU op per requester: 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor.
- alu_A  output  DATA_WIDTH  to ALU operand A.
- alu_B  output  DATA_WIDTH  to ALU operand B.
- alu_cntrl  output  3  to ALU cntrl.
- alu_result  input  DATA_WIDTH  from ALU.
- alu_flags  input  4  from ALU, ordered {negative, zero, overflow, carry_out}.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  ID_WIDTH  index of the requester that issued the operation.
- rsp_result  output  DATA_WIDTH  captured result.
- rsp_flags  output  4  captured {negative, zero, overflow, carry_out}.
- rsp_illegal  output  1  op code was 001 or 111.

Behaviour:
- Reset values:
  - Issue stage: op_valid=0.
  - Response stage: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, rsp_illegal=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has top priority first.
  - alu_A, alu_B and alu_cntrl drive 0 while op_valid=0.
- Two registered stages:
  - ISSUE (op_valid, op_A, op_B, op_cntrl, op_id, op_illegal) drives alu_* combinationally.
  - RESP captures the ALU outputs.
- Stage advance rules:
  - rsp_load = op_valid && (!rsp_valid || rsp_ready).
  - issue_free = !op_valid || rsp_load.
- Arbitration (combinational):
  - Search from last_grant+1 upward, wrapping modulo NUM_REQ; the first i with req_valid[i] wins.
  - req_ready[i]=1 only for the winner, and only when issue_free=1.
  - Handshake on requester i = req_valid[i] && req_ready[i].
  - On a handshake: load the ISSUE registers, set op_valid=1, last_grant=i.
  - last_grant does not move when no handshake occurs.
- Requester rule: once req_valid is raised it stays high with stable payload until accepted. The arbiter does not depend on this for correctness; a requester that drops early simply loses its turn.
- RESP loading and clearing:
  - When rsp_load: rsp_* take alu_result, alu_flags and op_id; rsp_valid=1.
  - If op_illegal: rsp_result=0, rsp_flags=0, rsp_illegal=1. The ALU output is ignored.
  - When op_valid && !rsp_load, ISSUE holds. The alu_* outputs stay stable.
  - When rsp_valid && rsp_ready && !rsp_load: rsp_valid=0. The data fields hold their last value.
- Latency and throughput:
  - A request accepted at edge k gives rsp_valid=1 after edge k+1 at the earliest.
  - With rsp_ready held high, one response is produced per cycle.
  - Responses leave in acceptance order; there is no reordering.
- Backpressure: with rsp_ready=0, at most two operations are held (RESP plus ISSUE), then all req_ready=0.
- Simultaneous events: an ISSUE handshake, RESP load and RESP drain in the same edge are all legal and required for full throughput.
- Reset mid-operation: in-flight ISSUE and RESP contents are discarded with no response. Reset overrides every other update in the same cycle.
- No combinational path from rsp_ready to rsp_valid. req_ready may depend combinationally on rsp_ready and req_valid.

Test Plan:
- Add: DATA_WIDTH=64, NUM_REQ=2; req0 A=5 B=7 cntrl=010, rsp_ready=1 -> req_ready[0] at cycle 0; rsp_valid the cycle after accept; rsp_result=12, rsp_id=0, rsp_flags=0000, rsp_illegal=0.
- Round-robin with subtract: both requesters hold valid for 6 cycles with sub A=3 B=3 -> grants 0,1,0,1,0,1; every response result=0, flags zero=1, carry_out=1, negative=0, overflow=0.
- Backpressure: rsp_ready=0 for 5 cycles with req0 continuously valid -> exactly 2 accepts, then req_ready=0. rsp_* stay stable. After release, 2 responses drain in order, then one per cycle.
- Illegal op: req1 cntrl=111 -> response rsp_id=1, rsp_illegal=1, rsp_result=0, rsp_flags=0000. A following req0 add is unaffected.
- Overflow: add A=0x7FFF_FFFF_FFFF_FFFF B=1 -> rsp_result=0x8000_0000_0000_0000, negative=1, overflow=1, zero=0, carry_out=0.
- Reset mid-operation: assert reset for 1 cycle while op_valid=1 and rsp_valid=1 -> next cycle rsp_valid=0, no response for discarded ops, requester 0 wins the next contention.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU among NUM_REQ requesters
// Two registered stages: ISSUE drives the ALU, RESP captures its result and flags.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 2,
  parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_A,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_B,
  input  logic [NUM_REQ*3-1:0]          req_cntrl,
  output logic [DATA_WIDTH-1:0]         alu_A,
  output logic [DATA_WIDTH-1:0]         alu_B,
  output logic [2:0]                    alu_cntrl,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  input  logic [3:0]                    alu_flags,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic [3:0]                    rsp_flags,
  output logic                          rsp_illegal
);

  localparam logic [ID_WIDTH:0]   NUM_REQ_W  = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] LAST_RESET = ID_WIDTH'(NUM_REQ - 1);

  logic                  op_valid;
  logic [DATA_WIDTH-1:0] op_A;
  logic [DATA_WIDTH-1:0] op_B;
  logic [2:0]            op_cntrl;
  logic [ID_WIDTH-1:0]   op_id;
  logic                  op_illegal;
  logic [ID_WIDTH-1:0]   last_grant;

  logic [ID_WIDTH-1:0]   grant_id;
  logic                  grant_found;
  logic [ID_WIDTH:0]     cand;
  logic                  rsp_load;
  logic                  issue_free;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_A;
  logic [DATA_WIDTH-1:0] sel_B;
  logic [2:0]            sel_cntrl;
  logic                  sel_illegal;

  assign rsp_load   = op_valid && (!rsp_valid || rsp_ready);
  assign issue_free = !op_valid || rsp_load;
  assign accept     = grant_found && issue_free;

  // Scan starts one past the last winner and wraps, so the last winner is visited last.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + (ID_WIDTH+1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!grant_found && req_valid[cand[ID_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_comb begin
    sel_A       = req_A[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    sel_B       = req_B[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    sel_cntrl   = req_cntrl[int'(grant_id)*3 +: 3];
    sel_illegal = (sel_cntrl == 3'b001) || (sel_cntrl == 3'b111);
  end

  // The ALU sees zeros whenever ISSUE is empty.
  assign alu_A     = op_valid ? op_A : '0;
  assign alu_B     = op_valid ? op_B : '0;
  assign alu_cntrl = op_valid ? op_cntrl : 3'b000;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_valid    <= 1'b0;
      op_A        <= '0;
      op_B        <= '0;
      op_cntrl    <= 3'b000;
      op_id       <= '0;
      op_illegal  <= 1'b0;
      last_grant  <= LAST_RESET;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_result  <= '0;
      rsp_flags   <= 4'b0000;
      rsp_illegal <= 1'b0;
    end else begin
      if (accept) begin
        op_valid   <= 1'b1;
        op_A       <= sel_A;
        op_B       <= sel_B;
        op_cntrl   <= sel_cntrl;
        op_id      <= grant_id;
        op_illegal <= sel_illegal;
        last_grant <= grant_id;
      end else if (rsp_load) begin
        op_valid <= 1'b0;
      end

      if (rsp_load) begin
        rsp_valid   <= 1'b1;
        rsp_id      <= op_id;
        rsp_illegal <= op_illegal;
        rsp_result  <= op_illegal ? '0 : alu_result;
        rsp_flags   <= op_illegal ? 4'b0000 : alu_flags;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
// Drives an ALU stand-in and compares against an in-flight queue model every cycle.
module tb_alu_share_arbiter;

  localparam int DW  = 64;
  localparam int N   = 2;
  localparam int IDW = 1;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_A;
  logic [N*DW-1:0] req_B;
  logic [N*3-1:0]  req_cntrl;
  logic [DW-1:0]   alu_A;
  logic [DW-1:0]   alu_B;
  logic [2:0]      alu_cntrl;
  logic [DW-1:0]   alu_result;
  logic [3:0]      alu_flags;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [DW-1:0]   rsp_result;
  logic [3:0]      rsp_flags;
  logic            rsp_illegal;

  logic [DW-1:0]   a_in [N];
  logic [DW-1:0]   b_in [N];
  logic [2:0]      c_in [N];

  int n_checks = 0;
  int n_pass   = 0;

  alu_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .ID_WIDTH(IDW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_cntrl(req_cntrl),
    .alu_A(alu_A), .alu_B(alu_B), .alu_cntrl(alu_cntrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_illegal(rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_A[i*DW +: DW]   = a_in[i];
      req_B[i*DW +: DW]   = b_in[i];
      req_cntrl[i*3 +: 3] = c_in[i];
    end
  end

  // ALU stand-in: {negative, zero, overflow, carry_out, result}; illegal codes give junk.
  function automatic logic [DW+3:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [2:0] c);
    logic [DW:0]   s;
    logic [DW-1:0] r;
    logic          cy;
    logic          ov;
    cy = 1'b0;
    ov = 1'b0;
    r  = '0;
    s  = '0;
    case (c)
      3'b000: r = b;
      3'b010: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[DW-1:0];
        cy = s[DW];
        ov = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      3'b011: begin
        s  = {1'b0, a} + {1'b0, ~b} + 65'd1;
        r  = s[DW-1:0];
        cy = s[DW];
        ov = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: return {4'b1111, a ^ 64'hDEAD_BEEF_0BAD_F00D};
    endcase
    return {r[DW-1], (r == '0), ov, cy, r};
  endfunction

  assign {alu_flags, alu_result} = alu_fn(alu_A, alu_B, alu_cntrl);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: in-flight operations in acceptance order. An op is visible as the
  // response one edge after acceptance once it is the oldest; at most two are in flight
  // after the oldest visible one drains.
  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [2:0]     c;
    logic [DW-1:0]  res;
    logic [3:0]     fl;
    logic           ill;
    int             e;
  } item_t;

  item_t        q[$];
  item_t        it;
  item_t        iss;
  bit           live = 0;
  int           edge_cnt = 0;
  int           last_g;
  int           win;
  int           idx;
  int           remaining;
  bit           vis;
  bit           drain;
  bit           has_iss;
  logic [N-1:0] exp_ready;
  logic [N-1:0] acc_mask = '0;

  always @(negedge clk) begin
    if (!live) begin
      acc_mask = '0;
      if (reset) begin
        q.delete();
        last_g = N - 1;
        live   = 1;
      end
    end else begin
      vis       = (q.size() > 0) && (q[0].e < edge_cnt);
      drain     = vis && rsp_ready;
      remaining = q.size() - (drain ? 1 : 0);
      win = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (last_g + k) % N;
        if (win < 0 && req_valid[idx]) win = idx;
      end
      exp_ready = '0;
      if (win >= 0 && remaining < 2) exp_ready[win] = 1'b1;

      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("rsp_valid", 64'(rsp_valid), 64'(vis));
      if (vis) begin
        chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
        chk("rsp_result", rsp_result, q[0].res);
        chk("rsp_flags", 64'(rsp_flags), 64'(q[0].fl));
        chk("rsp_illegal", 64'(rsp_illegal), 64'(q[0].ill));
      end
      has_iss = 0;
      if (q.size() == 2) begin
        has_iss = 1; iss = q[1];
      end else if (q.size() == 1 && !vis) begin
        has_iss = 1; iss = q[0];
      end
      chk("alu_A", alu_A, has_iss ? iss.a : 64'd0);
      chk("alu_B", alu_B, has_iss ? iss.b : 64'd0);
      chk("alu_cntrl", 64'(alu_cntrl), has_iss ? 64'(iss.c) : 64'd0);

      acc_mask = reset ? '0 : (req_valid & req_ready);
      if (reset) begin
        q.delete();
        last_g = N - 1;
      end else begin
        if (drain) void'(q.pop_front());
        if (win >= 0 && remaining < 2) begin
          it.id = IDW'(win);
          it.a  = a_in[win];
          it.b  = b_in[win];
          it.c  = c_in[win];
          it.e  = edge_cnt + 1;
          if (it.c == 3'b001 || it.c == 3'b111) begin
            it.res = '0; it.fl = 4'b0000; it.ill = 1'b1;
          end else begin
            {it.fl, it.res} = alu_fn(it.a, it.b, it.c);
            it.ill = 1'b0;
          end
          q.push_back(it);
          last_g = win;
        end
      end
      edge_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [2:0] c);
    a_in[i] = a;
    b_in[i] = b;
    c_in[i] = c;
    req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd64();
    case ($urandom % 6)
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      4:       return 64'($urandom % 16);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  int nacc;

  initial begin
    reset = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      a_in[i] = '0; b_in[i] = '0; c_in[i] = 3'b000;
    end
    repeat (2) cyc();
    reset = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_result", rsp_result, 64'd0);
    chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
    chk("rst_rsp_illegal", 64'(rsp_illegal), 64'd0);
    chk("rst_alu_A", alu_A, 64'd0);

    // add 5+7
    set_req(0, 64'd5, 64'd7, 3'b010);
    rsp_ready = 1'b1;
    #1;
    chk("add_ready", 64'(req_ready), 64'h1);
    cyc();
    req_valid = '0;
    #1;
    chk("add_latency", 64'(rsp_valid), 64'd0);
    chk("add_alu_A", alu_A, 64'd5);
    cyc();
    chk("add_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("add_result", rsp_result, 64'd12);
    chk("add_id", 64'(rsp_id), 64'd0);
    chk("add_flags", 64'(rsp_flags), 64'd0);
    chk("add_illegal", 64'(rsp_illegal), 64'd0);

    // round robin with 3-3
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 64'd3, 64'd3, 3'b011);
    set_req(1, 64'd3, 64'd3, 3'b011);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_grant", 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      if (k >= 2) begin
        chk("rr_valid", 64'(rsp_valid), 64'd1);
        chk("rr_id", 64'(rsp_id), 64'(k % 2));
        chk("rr_result", rsp_result, 64'd0);
        chk("rr_flags", 64'(rsp_flags), 64'b0101);
      end
      cyc();
    end
    req_valid = '0;
    #1;
    chk("rr_tail0_id", 64'(rsp_id), 64'd0);
    cyc();
    chk("rr_tail1_id", 64'(rsp_id), 64'd1);
    chk("rr_tail1_flags", 64'(rsp_flags), 64'b0101);
    cyc();

    // backpressure
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 64'd10, 64'd1, 3'b010);
    nacc = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (req_ready[0]) begin
        nacc++;
        cyc();
        a_in[0] = 64'(10 * (nacc + 1));
      end else begin
        cyc();
      end
    end
    #1;
    chk("bp_accepts", 64'(nacc), 64'd2);
    chk("bp_ready", 64'(req_ready), 64'd0);
    chk("bp_held_valid", 64'(rsp_valid), 64'd1);
    chk("bp_held_result", rsp_result, 64'd11);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'h1);
    cyc();
    req_valid = '0;
    chk("bp_drain2", rsp_result, 64'd21);
    cyc();
    chk("bp_drain3", rsp_result, 64'd31);
    cyc();
    chk("bp_empty", 64'(rsp_valid), 64'd0);

    // illegal op followed by an add
    do_reset();
    rsp_ready = 1'b1;
    set_req(1, 64'd9, 64'd9, 3'b111);
    #1;
    chk("ill_ready", 64'(req_ready), 64'h2);
    cyc();
    req_valid = '0;
    set_req(0, 64'd1, 64'd1, 3'b010);
    cyc();
    req_valid = '0;
    chk("ill_id", 64'(rsp_id), 64'd1);
    chk("ill_flag", 64'(rsp_illegal), 64'd1);
    chk("ill_result", rsp_result, 64'd0);
    chk("ill_flags", 64'(rsp_flags), 64'd0);
    cyc();
    chk("ill_next_id", 64'(rsp_id), 64'd0);
    chk("ill_next_result", rsp_result, 64'd2);
    chk("ill_next_illegal", 64'(rsp_illegal), 64'd0);

    // signed overflow
    set_req(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
    cyc();
    req_valid = '0;
    cyc();
    chk("ovf_result", rsp_result, 64'h8000_0000_0000_0000);
    chk("ovf_flags", 64'(rsp_flags), 64'b1010);
    cyc();

    // reset with both stages occupied
    rsp_ready = 1'b0;
    set_req(0, 64'd4, 64'd4, 3'b100);
    cyc();
    cyc();
    chk("midrst_pre", 64'(rsp_valid), 64'd1);
    set_req(1, 64'd6, 64'd6, 3'b101);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrst_valid", 64'(rsp_valid), 64'd0);
    #1;
    chk("midrst_grant", 64'(req_ready), 64'h1);
    rsp_ready = 1'b1;
    cyc();
    req_valid[0] = 1'b0;
    cyc();
    req_valid = '0;
    chk("midrst_rsp0", rsp_result, 64'd4);
    cyc();
    chk("midrst_rsp1", rsp_result, 64'd6);
    cyc();

    // randomized traffic
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      cyc();
      reset = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (acc_mask[i]) begin
            if ($urandom % 2 == 0) set_req(i, rnd64(), rnd64(), 3'($urandom));
            else req_valid[i] = 1'b0;
          end else if ($urandom % 16 == 0) begin
            req_valid[i] = 1'b0;
          end
        end else if ($urandom % 2 == 0) begin
          set_req(i, rnd64(), rnd64(), 3'($urandom));
        end
      end
      rsp_ready = ($urandom % 10) < 7;
      reset = ($urandom % 400) == 0;
    end
    reset = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
